uart_rx_unit: RTL

//  Receive half of the MiniUart: samples the serial line on a 16x oversampling tick and recovers
//  8N1 frames (start 0, 8 data bits LSB-first, stop 1). Sits downstream of the transmit unit's
//  txd line. Presents the received byte plus status flags to the bus-side UART register logic.

---
 rtl/uart_rx_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - 8N1 UART receiver with 16x oversampling and status flags
//
// Purpose:
//   Recovers start/data/stop frames from the asynchronous rxd line. The line is
//   sampled on en_rx oversampling ticks. The received byte and its status flags
//   are presented to the bus-side register logic.
//
// Ports:
//   clk     in   1          system clock
//   rst     in   1          asynchronous, active-high reset
//   rxd     in   1          serial input, asynchronous to clk, idles high
//   en_rx   in   1          oversampling tick, one clk wide, OVERSAMPLE per bit
//   clr_rs  in   1          read acknowledge, clears rs/fe/oe
//   d_out   out  DATA_BITS  last received byte, held until the next frame completes
//   rs      out  1          byte available (sticky)
//   fe      out  1          framing error on last frame (stop bit sampled 0)
//   oe      out  1          overrun: frame completed while rs was still set

module uart_rx_unit #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 en_rx,
    input  logic                 clr_rs,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rs,
    output logic                 fe,
    output logic                 oe
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_p;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_d_out;
    logic                   r_rs;
    logic                   r_fe;
    logic                   r_oe;

    logic                   w_rxd_s;
    logic                   w_done;

    assign w_rxd_s = r_sync[SYNC_STAGES-1];

    // Stop-bit sample edge: the frame is delivered on this clk edge.
    assign w_done = en_rx && (r_state == S_STOP) && (r_cnt == CNT_LAST);

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    // Previous-tick line sample used for start-edge detection. A line held low
    // keeps r_rxd_p at 0, so a break never retriggers until a high tick is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_p <= 1'b1;
        end else if (en_rx) begin
            r_rxd_p <= w_rxd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (en_rx) begin
            case (r_state)
                S_IDLE: begin
                    if (r_rxd_p && !w_rxd_s) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        // High at mid start bit is a glitch: abandon silently.
                        r_state   <= w_rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Frame completion has priority over a read acknowledge on the same edge;
    // the acknowledge then only suppresses the overrun (old byte counts as read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_out <= '0;
            r_rs    <= 1'b0;
            r_fe    <= 1'b0;
            r_oe    <= 1'b0;
        end else if (w_done) begin
            r_d_out <= r_shift;
            r_rs    <= 1'b1;
            r_fe    <= ~w_rxd_s;
            r_oe    <= (r_rs | r_oe) & ~clr_rs;
        end else if (clr_rs) begin
            r_rs <= 1'b0;
            r_fe <= 1'b0;
            r_oe <= 1'b0;
        end
    end

    assign d_out = r_d_out;
    assign rs    = r_rs;
    assign fe    = r_fe;
    assign oe    = r_oe;

endmodule
